// File: rtl/trgg_cmd_rx.sv
// Command framer for the trigger generator: HEAD + 5 payload bytes + XOR checksum -> 40-bit trgg_cmd, then fs/fd handshake.
// Latency: trgg_cmd valid the cycle after the checksum byte; fs rises the cycle after that.
// Backpressure: none on the byte stream; bytes arriving while busy are dropped and flagged as overrun.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   rx_data/rx_valid  byte stream from the host link (bit 0 = MSB), one-cycle strobe per byte
//   trgg_cmd          latched command, [0:7] mode, [8:39] delay
//   fs / fd           start request out / done acknowledge in
//   busy              high in LOAD, WORK and DONE
//   err / err_code    one-cycle error pulse; code 01 checksum, 10 timeout, 11 overrun
module trgg_cmd_rx #(
    parameter logic [7:0] HEAD    = 8'hA5,
    parameter int         TIMEOUT = 1000,
    parameter int         TW      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:7]  rx_data,
    input  logic        rx_valid,
    output logic [0:39] trgg_cmd,
    output logic        fs,
    input  logic        fd,
    output logic        busy,
    output logic        err,
    output logic [0:1]  err_code
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PAY  = 3'd1,
        CHK  = 3'd2,
        LOAD = 3'd3,
        WORK = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam logic [1:0] CODE_CHK = 2'b01;
    localparam logic [1:0] CODE_TO  = 2'b10;
    localparam logic [1:0] CODE_OVR = 2'b11;

    // Counter value seen during the last allowed idle cycle; an idle cycle
    // observed at this value is the one that makes the count reach TIMEOUT.
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    state_t        state, state_nx;
    logic [2:0]    byte_cnt, byte_cnt_nx;
    logic [TW-1:0] to_cnt, to_cnt_nx;
    logic [0:39]   shreg, shreg_nx;
    logic [0:7]    xor_acc, xor_nx;
    logic [0:39]   cmd_nx;
    logic          err_nx;
    logic [0:1]    code_nx;

    // fs and busy are pure decodes of the state register, so an asynchronous
    // reset drops them in the same instant it forces IDLE.
    assign busy = (state == LOAD) || (state == WORK) || (state == DONE);
    assign fs   = (state == WORK);

    always_comb begin
        state_nx    = state;
        byte_cnt_nx = byte_cnt;
        to_cnt_nx   = to_cnt;
        shreg_nx    = shreg;
        xor_nx      = xor_acc;
        cmd_nx      = trgg_cmd;
        err_nx      = 1'b0;
        code_nx     = err_code;

        // Overrun: byte is dropped, FSM progress below is unaffected.
        if (rx_valid && busy) begin
            err_nx  = 1'b1;
            code_nx = CODE_OVR;
        end

        case (state)
            IDLE: begin
                // Anything other than HEAD is line noise between frames.
                if (rx_valid && (rx_data == HEAD)) begin
                    state_nx    = PAY;
                    byte_cnt_nx = 3'd0;
                    xor_nx      = 8'h00;
                    to_cnt_nx   = '0;
                end
            end

            PAY: begin
                // HEAD values are ordinary payload here; no resync.
                if (rx_valid) begin
                    shreg_nx    = {shreg[8:39], rx_data};
                    xor_nx      = xor_acc ^ rx_data;
                    byte_cnt_nx = byte_cnt + 3'd1;
                    to_cnt_nx   = '0;
                    if (byte_cnt == 3'd4) begin
                        state_nx = CHK;
                    end
                end else if (to_cnt == TO_LAST) begin
                    err_nx    = 1'b1;
                    code_nx   = CODE_TO;
                    to_cnt_nx = '0;
                    state_nx  = IDLE;
                end else begin
                    to_cnt_nx = to_cnt + TW'(1);
                end
            end

            CHK: begin
                if (rx_valid) begin
                    to_cnt_nx = '0;
                    if (rx_data == xor_acc) begin
                        // Command is registered on the way into LOAD so it is
                        // already visible during the LOAD cycle, one cycle
                        // ahead of fs.
                        cmd_nx   = shreg;
                        state_nx = LOAD;
                    end else begin
                        err_nx   = 1'b1;
                        code_nx  = CODE_CHK;
                        state_nx = IDLE;
                    end
                end else if (to_cnt == TO_LAST) begin
                    err_nx    = 1'b1;
                    code_nx   = CODE_TO;
                    to_cnt_nx = '0;
                    state_nx  = IDLE;
                end else begin
                    to_cnt_nx = to_cnt + TW'(1);
                end
            end

            LOAD: begin
                state_nx = WORK;
            end

            WORK: begin
                if (fd) begin
                    state_nx = DONE;
                end
            end

            DONE: begin
                if (!fd) begin
                    state_nx = IDLE;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            byte_cnt <= 3'd0;
            to_cnt   <= '0;
            shreg    <= '0;
            xor_acc  <= 8'h00;
            trgg_cmd <= '0;
            err      <= 1'b0;
            err_code <= 2'b00;
        end else begin
            state    <= state_nx;
            byte_cnt <= byte_cnt_nx;
            to_cnt   <= to_cnt_nx;
            shreg    <= shreg_nx;
            xor_acc  <= xor_nx;
            trgg_cmd <= cmd_nx;
            err      <= err_nx;
            err_code <= code_nx;
        end
    end

endmodule

// File: tb/tb_trgg_cmd_rx.sv
// Bench for trgg_cmd_rx: directed scenarios with literal expectations, then randomized frames.
// A frame-level model (byte queue, idle counter) predicts err/err_code/fs/busy/trgg_cmd every cycle.
// fd is driven manually in the directed part and by a random responder afterwards.
module tb_trgg_cmd_rx;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [0:7]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [0:39] trgg_cmd;
    logic        fs;
    logic        busy;
    logic        err;
    logic [0:1]  err_code;

    logic fd_man = 1'b0;
    logic fd_auto = 1'b0;
    logic auto_fd = 1'b0;
    logic fd_w;
    assign fd_w = auto_fd ? fd_auto : fd_man;

    int n_checks = 0;
    int n_pass   = 0;
    logic chk_on = 1'b0;

    trgg_cmd_rx #(.HEAD(8'hA5), .TIMEOUT(TO), .TW(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .trgg_cmd (trgg_cmd),
        .fs       (fs),
        .fd       (fd_w),
        .busy     (busy),
        .err      (err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // ph: 0 waiting for HEAD, 1 collecting payload, 2 awaiting checksum,
    //     3 command just accepted, 4 start requested, 5 waiting for fd release
    int          ph = 0;
    int          idle = 0;
    logic [7:0]  pay[$];
    logic [7:0]  mx;
    logic [39:0] mc;
    logic        m_err = 1'b0;
    logic [1:0]  m_code = 2'd0;
    logic [39:0] m_cmd = 40'd0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                ph = 0; idle = 0; pay.delete();
                m_err = 1'b0; m_code = 2'd0; m_cmd = 40'd0;
            end else begin
                m_err = 1'b0;
                if (rx_valid && ph >= 3) begin
                    m_err = 1'b1; m_code = 2'd3;
                end
                case (ph)
                    0: if (rx_valid && rx_data == 8'hA5) begin
                        ph = 1; idle = 0; pay.delete();
                    end
                    1, 2: begin
                        if (rx_valid) begin
                            idle = 0;
                            if (ph == 1) begin
                                pay.push_back(rx_data);
                                if (pay.size() == 5) ph = 2;
                            end else begin
                                mx = 8'h00;
                                foreach (pay[i]) mx ^= pay[i];
                                if (rx_data == mx) begin
                                    mc = 40'd0;
                                    foreach (pay[i]) mc = (mc << 8) | 40'(pay[i]);
                                    m_cmd = mc;
                                    ph = 3;
                                end else begin
                                    m_err = 1'b1; m_code = 2'd1; ph = 0;
                                end
                            end
                        end else begin
                            idle++;
                            if (idle == TO) begin
                                m_err = 1'b1; m_code = 2'd2; ph = 0;
                            end
                        end
                    end
                    3: ph = 4;
                    4: if (fd_w) ph = 5;
                    5: if (!fd_w) ph = 0;
                    default: ph = 0;
                endcase
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst && chk_on) begin
            check("err",      64'(err),      64'(m_err));
            check("err_code", 64'(err_code), 64'(m_code));
            check("fs",       64'(fs),       64'(ph == 4));
            check("busy",     64'(busy),     64'(ph >= 3));
            check("trgg_cmd", 64'(trgg_cmd), 64'(m_cmd));
        end
    end

    // ---------------- random fd responder ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (auto_fd) begin
                if (fs) begin
                    repeat ($urandom_range(0, 6)) @(negedge clk);
                    fd_auto = 1'b1;
                    for (int i = 0; i < 50 && fs; i++) @(negedge clk);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    fd_auto = 1'b0;
                end else if (!busy && $urandom_range(0, 19) == 0) begin
                    fd_auto = 1'b1;
                    @(negedge clk);
                    fd_auto = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic put(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    function automatic int gap_pick(input bit jitter);
        if (!jitter) return 0;
        if ($urandom_range(0, 11) == 0) return $urandom_range(6, 9);
        return $urandom_range(0, 2);
    endfunction

    // flip != 0 corrupts the checksum byte
    task automatic send_cmd(input logic [39:0] c, input logic [7:0] flip, input bit jitter);
        logic [39:0] t;
        logic [7:0]  b;
        logic [7:0]  ck;
        t  = c;
        ck = 8'h00;
        put(8'hA5, gap_pick(jitter));
        for (int i = 0; i < 5; i++) begin
            b  = t[39:32];
            t  = t << 8;
            ck ^= b;
            put(b, gap_pick(jitter));
        end
        put(ck ^ flip, 0);
    endtask

    task automatic handshake();
        int i;
        i = 0;
        while (!fs && i < 20) begin @(negedge clk); i++; end
        check("hs_fs_rise", 64'(fs), 64'd1);
        repeat (2) @(negedge clk);
        fd_man = 1'b1;
        i = 0;
        while (fs && i < 20) begin @(negedge clk); i++; end
        check("hs_fs_fall", 64'(fs), 64'd0);
        @(negedge clk);
        fd_man = 1'b0;
        i = 0;
        while (busy && i < 20) begin @(negedge clk); i++; end
        check("hs_busy_fall", 64'(busy), 64'd0);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 400; i++) begin
            if (!busy) break;
            if ($urandom_range(0, 7) == 0) put(8'($urandom_range(0, 255)), 0);
            else @(negedge clk);
        end
        check("drain_idle", 64'(busy), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [39:0] rc;
        int          kind;
        int          n;

        #1;
        check("rst_err",      64'(err),      64'd0);
        check("rst_err_code", 64'(err_code), 64'd0);
        check("rst_fs",       64'(fs),       64'd0);
        check("rst_busy",     64'(busy),     64'd0);
        check("rst_cmd",      64'(trgg_cmd), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_on = 1'b1;

        // valid frame with hand-timed fd
        send_cmd(40'h12000001F4, 8'h00, 1'b0);
        check("vf_cmd",       64'(trgg_cmd), 64'h12000001F4);
        check("vf_model_cmd", 64'(m_cmd),    64'h12000001F4);
        check("vf_fs_load",   64'(fs),       64'd0);
        check("vf_busy_load", 64'(busy),     64'd1);
        @(negedge clk);
        check("vf_fs_rise",   64'(fs),       64'd1);
        repeat (4) @(negedge clk);
        fd_man = 1'b1;
        @(negedge clk);
        check("vf_fs_fall",   64'(fs),       64'd0);
        check("vf_busy_done", 64'(busy),     64'd1);
        @(negedge clk);
        fd_man = 1'b0;
        @(negedge clk);
        check("vf_busy_end",  64'(busy),     64'd0);

        // bad checksum (E6)
        send_cmd(40'h12000001F4, 8'h01, 1'b0);
        check("ck_err",      64'(err),      64'd1);
        check("ck_code",     64'(err_code), 64'd1);
        check("ck_cmd_keep", 64'(trgg_cmd), 64'h12000001F4);
        check("ck_fs",       64'(fs),       64'd0);
        @(negedge clk);
        check("ck_err_drop", 64'(err),      64'd0);
        check("ck_code_hold", 64'(err_code), 64'd1);

        // leading junk then valid frame (34 00 00 00 10, CK 24)
        put(8'h00, 0); put(8'hFF, 0); put(8'h5A, 0);
        check("junk_no_err", 64'(err), 64'd0);
        send_cmd(40'h3400000010, 8'h00, 1'b0);
        check("junk_cmd", 64'(trgg_cmd), 64'h3400000010);
        handshake();

        // timeout: byte on the 8th idle cycle wins, then a real expiry in CHK
        put(8'hA5, 0);
        put(8'h12, 7);
        put(8'h00, 0);
        check("to_corner_no_err", 64'(err), 64'd0);
        repeat (6) @(negedge clk);
        put(8'h00, 0);
        put(8'h01, 0);
        put(8'hF4, 7);
        check("to_before_expiry", 64'(err), 64'd0);
        @(negedge clk);
        check("to_err",  64'(err),      64'd1);
        check("to_code", 64'(err_code), 64'd2);
        @(negedge clk);
        check("to_err_drop", 64'(err), 64'd0);
        send_cmd(40'h12000001F4, 8'h00, 1'b0);
        check("to_reload_cmd", 64'(trgg_cmd), 64'h12000001F4);
        handshake();

        // overrun during WORK, then asynchronous reset mid-WORK
        send_cmd(40'h3400000010, 8'h00, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            put(8'h5A + 8'(k), 0);
            check("ovr_err",  64'(err),      64'd1);
            check("ovr_code", 64'(err_code), 64'd3);
            check("ovr_fs",   64'(fs),       64'd1);
            check("ovr_cmd",  64'(trgg_cmd), 64'h3400000010);
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        check("arst_fs",   64'(fs),       64'd0);
        check("arst_busy", 64'(busy),     64'd0);
        check("arst_cmd",  64'(trgg_cmd), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        send_cmd(40'hA5FF00A501, 8'h00, 1'b0);
        check("post_rst_cmd", 64'(trgg_cmd), 64'hA5FF00A501);
        handshake();

        // randomized traffic against the model
        auto_fd = 1'b1;
        for (int f = 0; f < 80; f++) begin
            kind = $urandom_range(0, 9);
            rc   = {8'($urandom_range(0, 255)), 32'($urandom)};
            case (kind)
                0: begin
                    n = $urandom_range(1, 3);
                    for (int j = 0; j < n; j++) put(8'($urandom_range(0, 164)), 0);
                    send_cmd(rc, 8'h00, 1'b1);
                end
                1: send_cmd(rc, 8'($urandom_range(1, 255)), 1'b1);
                2: begin
                    put(8'hA5, 0);
                    n = $urandom_range(0, 5);
                    for (int j = 0; j < n; j++) put(8'($urandom_range(0, 255)), 0);
                    repeat ($urandom_range(7, 10)) @(negedge clk);
                end
                default: send_cmd(rc, 8'h00, 1'b1);
            endcase
            drain();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        auto_fd = 1'b0;
        repeat (20) @(negedge clk);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/trgg_cmd_rx.md
Name: trgg_cmd_rx

Overview:
- Upstream command framer for the trigger generator.
- Receives a byte stream from the host link, assembles a 40-bit trigger command (8-bit mode, 32-bit delay), validates it, and presents it on trgg_cmd.
- Issues the fs/fd start handshake to the trigger generator.
- Flags checksum, inter-byte timeout and overrun errors.

Parameters:
- HEAD, 8'hA5, frame header byte.
- TIMEOUT, 1000, maximum idle clk cycles allowed between consecutive bytes inside a frame.
- TW, 16, width of the timeout counter; TIMEOUT < 2^TW.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- rx_data  input  [0:7]  received byte; bit 0 is the MSB.
- rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle.
- trgg_cmd  output  [0:39]  latched command; [0:7] is mod, [8:39] is delay, MSB first.
- fs  output  1  start request to the trigger generator.
- fd  input  1  done acknowledge from the trigger generator.
- busy  output  1  high in LOAD, WORK and DONE.
- err  output  1  one-cycle error pulse.
- err_code  output  [0:1]  valid while err=1: 01 checksum, 10 timeout, 11 overrun.

Behaviour:
- Clock and reset: single clock, clk. rst is asynchronous and active-high. Reset forces state IDLE, trgg_cmd=0, fs=0, busy=0, err=0, err_code=0, byte counter=0, timeout counter=0, shift register=0, running XOR=0. Reset mid-frame or mid-handshake discards all partial data; fs drops immediately.
- Frame format: HEAD, then P0..P4 (P0=mod, P1..P4=delay MSB first), then CK. CK = P0^P1^P2^P3^P4.
- IDLE: on rx_valid with rx_data==HEAD, go to PAY and clear the byte counter and XOR. Any other byte is ignored silently, with no err.
- PAY: each rx_valid shifts the byte into a 40-bit shift register (left, new byte at [32:39]) and XORs it into the running XOR. After the 5th byte, go to CHK. HEAD bytes inside PAY are data, so there is no resync.
- CHK: on rx_valid, if rx_data equals the running XOR, go to LOAD. Otherwise pulse err with code 01 and go to IDLE; trgg_cmd is unchanged.
- LOAD: one cycle. Copy the shift register into trgg_cmd, then go to WORK. trgg_cmd is stable from that point until the next LOAD.
- WORK: fs=1. Hold until fd=1 is sampled, then go to DONE with fs=0 registered the next cycle.
- DONE: fs=0. Wait for fd=0, then go to IDLE. busy deasserts on entry to IDLE.
- Latency: trgg_cmd updates 1 cycle after the CK byte cycle. fs rises 2 cycles after the CK byte cycle.
- Timeout: applies in PAY and CHK only.
  - The counter clears on every rx_valid and on entry to PAY.
  - It increments each cycle without rx_valid.
  - When it reaches TIMEOUT, pulse err with code 10 and go to IDLE.
  - If rx_valid arrives in the expiry cycle, the byte wins and no timeout occurs.
- Overrun: rx_valid while busy=1 drops the byte, pulses err with code 11, and leaves state and fs unchanged.
- Error reporting: err is registered, at most one event per cycle, high for exactly 1 cycle. err_code holds its last value when err=0.
- fd=1 observed in IDLE, PAY or CHK is ignored.

Test Plan:
- Valid frame: send A5 12 00 00 01 F4 E7 on successive cycles, then assert fd 5 cycles after fs rises and deassert it 2 cycles later.
  -> trgg_cmd=0x12000001F4 one cycle after E7; fs rises next cycle and falls the cycle after fd; busy is low after fd falls; err is never asserted.
- Bad checksum: send A5 12 00 00 01 F4 E6.
  -> err=1 with err_code=01 for one cycle; trgg_cmd retains its previous value; fs stays 0; state returns to IDLE (a following valid frame is accepted).
- Leading junk: send 00 FF 5A, then the valid frame.
  -> no err; the command loads as in the valid-frame scenario.
- Timeout: with TIMEOUT=8, send A5 12, then no bytes.
  -> err with code 10 exactly 8 cycles after the 12 byte. A full valid frame afterwards loads normally.
  - Corner case: a byte arriving on the 8th idle cycle resets the counter and raises no err.
- Overrun and reset: send 3 bytes while fs=1.
  -> three err pulses with code 11; fs stays 1; trgg_cmd is unchanged.
  - Then assert rst mid-WORK: fs, busy and trgg_cmd go to 0 asynchronously; after release, a new valid frame works.
